// File: rtl/shared_data_tx_sched_m_if.sv
// rtl/shared_data_tx_sched_m_if.sv - req/ack/done handshake between the tx scheduler and the stream generator
interface shared_data_tx_sched_m_if #(
    parameter int SEG_AW = 3
);
    logic              tx_req;
    logic [SEG_AW-1:0] tx_seg;
    logic              tx_ack;
    logic              tx_done;

    modport master (output tx_req, output tx_seg, input tx_ack, input tx_done);
    modport slave  (input tx_req, input tx_seg, output tx_ack, output tx_done);
endinterface

// File: rtl/shared_data_tx_sched_m.sv
// rtl/shared_data_tx_sched_m.sv - round-robin dirty-segment scheduler for the shared-data stream generator
module shared_data_tx_sched_m #(
    parameter int SEG_COUNT      = 8,
    parameter int SEG_AW         = $clog2(SEG_COUNT),
    parameter int REFRESH_PERIOD = 1000000,
    parameter int TIMEOUT        = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     seg_wr_valid,
    input  logic [SEG_AW-1:0]        seg_wr_idx,
    input  logic                     refresh_ena,
    shared_data_tx_sched_m_if.master tx,
    output logic                     busy,
    output logic [SEG_COUNT-1:0]     dirty,
    output logic [15:0]              coalesce_cnt,
    output logic [15:0]              timeout_cnt
);
    localparam int RW = $clog2(REFRESH_PERIOD);
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]           state;
    logic [SEG_AW-1:0]    ptr;
    logic [SEG_AW-1:0]    seg;
    logic [SEG_AW-1:0]    cand;
    logic [SEG_AW-1:0]    ptr_next;
    logic [SEG_AW:0]      scan;
    logic                 found;
    logic [RW-1:0]        refresh_cnt;
    logic                 refresh_fire;
    logic [TW-1:0]        to_cnt;
    logic                 to_expire;
    logic                 wr_hit;
    logic [SEG_COUNT-1:0] dirty_set;
    logic [SEG_COUNT-1:0] dirty_clr;

    assign tx.tx_req = (state == ST_REQ);
    assign tx.tx_seg = seg;
    assign busy      = (state != ST_IDLE);

    assign refresh_fire = refresh_ena && (refresh_cnt == RW'(REFRESH_PERIOD - 1));
    assign to_expire    = (to_cnt == TW'(TIMEOUT - 1));
    assign ptr_next     = (seg == SEG_AW'(SEG_COUNT - 1)) ? '0 : seg + SEG_AW'(1);

    // First dirty segment at or after ptr, wrapping past the last segment.
    always_comb begin
        cand  = '0;
        found = 1'b0;
        scan  = '0;
        for (int i = 0; i < SEG_COUNT; i++) begin
            scan = {1'b0, ptr} + (SEG_AW+1)'(i);
            if (scan >= (SEG_AW+1)'(SEG_COUNT))
                scan = scan - (SEG_AW+1)'(SEG_COUNT);
            if (!found && dirty[scan[SEG_AW-1:0]]) begin
                cand  = scan[SEG_AW-1:0];
                found = 1'b1;
            end
        end
    end

    // Sets are applied after the pick-clear so a same-cycle write or refresh keeps the bit.
    always_comb begin
        wr_hit    = seg_wr_valid && ({1'b0, seg_wr_idx} < (SEG_AW+1)'(SEG_COUNT));
        dirty_set = '0;
        if (wr_hit)
            dirty_set[seg_wr_idx] = 1'b1;
        if (refresh_fire)
            dirty_set = '1;
        if (state == ST_WAIT && !tx.tx_done && to_expire)
            dirty_set[seg] = 1'b1;
        dirty_clr = '0;
        if (state == ST_IDLE && found)
            dirty_clr[cand] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            seg          <= '0;
            refresh_cnt  <= '0;
            to_cnt       <= '0;
            dirty        <= '0;
            coalesce_cnt <= '0;
            timeout_cnt  <= '0;
        end else begin
            dirty <= (dirty & ~dirty_clr) | dirty_set;

            if (wr_hit && dirty[seg_wr_idx] && coalesce_cnt != 16'hFFFF)
                coalesce_cnt <= coalesce_cnt + 16'd1;

            if (!refresh_ena || refresh_fire)
                refresh_cnt <= '0;
            else
                refresh_cnt <= refresh_cnt + RW'(1);

            case (state)
                ST_IDLE: begin
                    if (found) begin
                        seg   <= cand;
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (tx.tx_ack) begin
                        to_cnt <= '0;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    to_cnt <= to_cnt + TW'(1);
                    if (tx.tx_done) begin
                        ptr   <= ptr_next;
                        state <= ST_IDLE;
                    end else if (to_expire) begin
                        if (timeout_cnt != 16'hFFFF)
                            timeout_cnt <= timeout_cnt + 16'd1;
                        ptr   <= ptr_next;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
